hazard_ctrl: RTL and testbench

- Pipeline controller for the 5-stage RV32I data_path (IF/ID/EX/MEM/WB).
- Generates the ALU and branch forwarding selects.
- Detects load-use and branch-operand hazards and inserts bubbles.
- Flushes IF/ID on taken branches, and freezes the whole pipeline while the data memory handshake is pending.

---
 rtl/rv_pipe_pkg.sv | 30 +++
 rtl/hazard_ctrl_if.sv | 16 +
 rtl/hazard_fwd_unit.sv | 68 ++++++
 rtl/hazard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pipe_pkg.sv
// -----------------------------------------------------------------------------
// rv_pipe_pkg
// Shared definitions for the 5-stage RV32I pipeline control logic:
//   - register address width and type
//   - ALU forward-select encodings
//   - hazard controller FSM states
//   - rd_hit(): "this stage writes a non-zero rd that matches rs"
// -----------------------------------------------------------------------------
package rv_pipe_pkg;

    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    // ALU operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // WB result
    localparam logic [1:0] FWD_MEM = 2'b10;  // MEM-stage ALU result

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // x0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic rd_hit(input logic we, input reg_addr_t rd, input reg_addr_t rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Data memory request/ready handshake seen by the pipeline controller.
//   dmem_req   : controller -> memory, access requested this cycle
//   dmem_ready : memory -> controller, access completes this cycle
// Modports: master (controller side), slave (memory side).
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;

    logic dmem_req;
    logic dmem_ready;

    modport master (output dmem_req, input  dmem_ready);
    modport slave  (input  dmem_req, output dmem_ready);

endinterface

// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
// Purely combinational forwarding selects and hazard detection.
// Inputs : ID/EX/MEM/WB register addresses, write enables, load flags.
// Outputs: alu_forward_a/b   ALU operand selects (FWD_RF/FWD_WB/FWD_MEM)
//          branch_forward_a/b MEM ALU result into the ID branch comparator
//          haz                ID instruction must stall one cycle
// -----------------------------------------------------------------------------
module hazard_fwd_unit
    import rv_pipe_pkg::*;
(
    input  reg_addr_t  id_rs1,
    input  reg_addr_t  id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       id_is_branch,
    input  reg_addr_t  ex_rs1,
    input  reg_addr_t  ex_rs2,
    input  reg_addr_t  ex_rd,
    input  logic       ex_rd_we,
    input  logic       ex_is_load,
    input  reg_addr_t  mem_rd,
    input  logic       mem_rd_we,
    input  logic       mem_is_load,
    input  reg_addr_t  wb_rd,
    input  logic       wb_rd_we,
    output logic [1:0] alu_forward_a,
    output logic [1:0] alu_forward_b,
    output logic       branch_forward_a,
    output logic       branch_forward_b,
    output logic       haz
);

    // A load in MEM has no data yet, so only MEM ALU results are forwardable.
    logic mem_alu_we;
    assign mem_alu_we = mem_rd_we && !mem_is_load;

    // MEM is newer than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input reg_addr_t rs);
        if (rd_hit(mem_alu_we, mem_rd, rs))
            return FWD_MEM;
        else if (rd_hit(wb_rd_we, wb_rd, rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign alu_forward_a = fwd_sel(ex_rs1);
    assign alu_forward_b = fwd_sel(ex_rs2);

    assign branch_forward_a = rd_hit(mem_alu_we, mem_rd, id_rs1);
    assign branch_forward_b = rd_hit(mem_alu_we, mem_rd, id_rs2);

    // ID source matches against the EX and MEM destinations, gated by use.
    logic ex_match;
    logic mem_ld_match;
    assign ex_match     = (id_use_rs1 && rd_hit(ex_rd_we, ex_rd, id_rs1)) ||
                          (id_use_rs2 && rd_hit(ex_rd_we, ex_rd, id_rs2));
    assign mem_ld_match = (id_use_rs1 && rd_hit(mem_is_load, mem_rd, id_rs1)) ||
                          (id_use_rs2 && rd_hit(mem_is_load, mem_rd, id_rs2));

    // Load-use, branch on an EX result, branch on a load still in MEM.
    // A load feeding a branch trips the second term then the third.
    assign haz = (ex_is_load && ex_match) ||
                 (id_is_branch && ex_match) ||
                 (id_is_branch && mem_ld_match);

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline controller for the 5-stage RV32I data path.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   dmem (hazard_ctrl_if.master)  data memory req/ready handshake
//   id_* / ex_* / mem_* / wb_*    stage register addresses and flags
//   branch_taken                  ID branch comparator result
//   alu_forward_a/b, branch_forward_a/b  forwarding selects
//   pc_en ... mem_wb_en           pipeline register enables
//   if_id_flush, id_ex_flush      NOP into IF/ID, bubble into ID/EX
//   mem_err                       sticky data memory timeout
//   stall_cnt, flush_cnt          wrapping performance counters
// Parameters:
//   DMEM_TIMEOUT  max MEM_WAIT cycles before abandoning the access (0 = never)
//   CNT_W         performance counter width
// -----------------------------------------------------------------------------
module hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 0,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_ctrl_if.master     dmem,
    input  reg_addr_t         id_rs1,
    input  reg_addr_t         id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_is_branch,
    input  logic              branch_taken,
    input  reg_addr_t         ex_rs1,
    input  reg_addr_t         ex_rs2,
    input  reg_addr_t         ex_rd,
    input  logic              ex_rd_we,
    input  logic              ex_is_load,
    input  reg_addr_t         mem_rd,
    input  logic              mem_rd_we,
    input  logic              mem_is_load,
    input  logic              mem_access,
    input  reg_addr_t         wb_rd,
    input  logic              wb_rd_we,
    output logic [1:0]        alu_forward_a,
    output logic [1:0]        alu_forward_b,
    output logic              branch_forward_a,
    output logic              branch_forward_b,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int WAIT_W = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              haz;
    logic              timeout_hit;
    logic              mem_stall;
    logic              stall_inc;
    logic              flush_inc;
    logic              err_set;

    hazard_fwd_unit u_fwd (
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_use_rs1       (id_use_rs1),
        .id_use_rs2       (id_use_rs2),
        .id_is_branch     (id_is_branch),
        .ex_rs1           (ex_rs1),
        .ex_rs2           (ex_rs2),
        .ex_rd            (ex_rd),
        .ex_rd_we         (ex_rd_we),
        .ex_is_load       (ex_is_load),
        .mem_rd           (mem_rd),
        .mem_rd_we        (mem_rd_we),
        .mem_is_load      (mem_is_load),
        .wb_rd            (wb_rd),
        .wb_rd_we         (wb_rd_we),
        .alu_forward_a    (alu_forward_a),
        .alu_forward_b    (alu_forward_b),
        .branch_forward_a (branch_forward_a),
        .branch_forward_b (branch_forward_b),
        .haz              (haz)
    );

    assign timeout_hit = (DMEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(DMEM_TIMEOUT - 1));

    // Freeze this cycle: a fresh access not ready in RUN, or an outstanding
    // access still not ready in MEM_WAIT. A timeout releases like a ready.
    always_comb begin
        mem_stall = 1'b0;
        if (state == RUN)
            mem_stall = mem_access && !dmem.dmem_ready;
        else
            mem_stall = !dmem.dmem_ready && !timeout_hit;
    end

    // The request is gated by rst_n so it drops the moment reset asserts,
    // even if the MEM stage still presents an access.
    assign dmem.dmem_req = rst_n && ((state == MEM_WAIT) || mem_access);

    // NOTE: every output of this block gets a default before any branch, so no
    // path can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        if (mem_stall) begin
            // Full freeze; flushes are suppressed so a held branch flushes
            // only once, on the release cycle.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            state_nxt = MEM_WAIT;
        end else begin
            state_nxt = RUN;
            if (haz) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (id_is_branch && branch_taken) begin
                if_id_flush = 1'b1;
            end
        end
    end

    // The RUN->MEM_WAIT entry cycle is not counted; every MEM_WAIT cycle,
    // including the release cycle, is.
    assign stall_inc = (state == MEM_WAIT) || (!mem_stall && haz);
    assign flush_inc = if_id_flush;
    assign err_set   = (state == MEM_WAIT) && !dmem.dmem_ready && timeout_hit;
    assign wait_nxt  = ((state == MEM_WAIT) && mem_stall) ? wait_cnt + WAIT_W'(1) : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            mem_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (stall_inc)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc)
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (err_set)
                mem_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed self-checking bench for hazard_ctrl (DMEM_TIMEOUT = 4).
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
    import rv_pipe_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    reg_addr_t       id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic            id_use_rs1, id_use_rs2, id_is_branch, branch_taken;
    logic            ex_rd_we, ex_is_load, mem_rd_we, mem_is_load, mem_access, wb_rd_we;
    logic [1:0]      alu_forward_a, alu_forward_b;
    logic            branch_forward_a, branch_forward_b;
    logic            pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic            if_id_flush, id_ex_flush, mem_err;
    logic [31:0]     stall_cnt, flush_cnt;
    logic [4:0]      en;

    int total = 0;
    int bad   = 0;

    hazard_ctrl_if dmem_bus ();

    hazard_ctrl #(.DMEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dmem             (dmem_bus),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_use_rs1       (id_use_rs1),
        .id_use_rs2       (id_use_rs2),
        .id_is_branch     (id_is_branch),
        .branch_taken     (branch_taken),
        .ex_rs1           (ex_rs1),
        .ex_rs2           (ex_rs2),
        .ex_rd            (ex_rd),
        .ex_rd_we         (ex_rd_we),
        .ex_is_load       (ex_is_load),
        .mem_rd           (mem_rd),
        .mem_rd_we        (mem_rd_we),
        .mem_is_load      (mem_is_load),
        .mem_access       (mem_access),
        .wb_rd            (wb_rd),
        .wb_rd_we         (wb_rd_we),
        .alu_forward_a    (alu_forward_a),
        .alu_forward_b    (alu_forward_b),
        .branch_forward_a (branch_forward_a),
        .branch_forward_b (branch_forward_b),
        .pc_en            (pc_en),
        .if_id_en         (if_id_en),
        .id_ex_en         (id_ex_en),
        .ex_mem_en        (ex_mem_en),
        .mem_wb_en        (mem_wb_en),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .mem_err          (mem_err),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    assign en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_is_branch = 0; branch_taken = 0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_rd_we = 0; ex_is_load = 0;
        mem_rd = '0; mem_rd_we = 0; mem_is_load = 0; mem_access = 0;
        wb_rd = '0; wb_rd_we = 0;
        dmem_bus.dmem_ready = 0;
    endtask

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst_n = 0;
        idle();
        mem_access = 1;
        #2;
        check("rst_req",   {31'd0, dmem_bus.dmem_req}, 32'd0);
        check("rst_stall", stall_cnt, 32'd0);
        check("rst_flush", flush_cnt, 32'd0);
        check("rst_err",   {31'd0, mem_err}, 32'd0);
        mem_access = 0;
        @(posedge clk); #1;
        rst_n = 1;
        #1;
        check("run_en",    {27'd0, en}, 32'h1f);
        check("run_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd0);

        // ---------------- ALU / branch forwarding ----------------
        mem_rd = 5; mem_rd_we = 1; wb_rd = 5; wb_rd_we = 1; ex_rs1 = 5; ex_rs2 = 5;
        #1;
        check("fwd_a_mem", {30'd0, alu_forward_a}, 32'd2);
        check("fwd_b_mem", {30'd0, alu_forward_b}, 32'd2);
        mem_rd_we = 0;
        #1;
        check("fwd_a_wb", {30'd0, alu_forward_a}, 32'd1);
        mem_rd_we = 1; mem_is_load = 1;
        #1;
        check("fwd_a_ld_in_mem", {30'd0, alu_forward_a}, 32'd1);
        mem_is_load = 0; id_rs1 = 5; id_rs2 = 6;
        #1;
        check("bfwd_a", {31'd0, branch_forward_a}, 32'd1);
        check("bfwd_b", {31'd0, branch_forward_b}, 32'd0);
        mem_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
        #1;
        check("fwd_a_x0", {30'd0, alu_forward_a}, 32'd0);
        check("fwd_b_x0", {30'd0, alu_forward_b}, 32'd0);

        // ---------------- load-use ----------------
        idle();
        ex_is_load = 1; ex_rd_we = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 0;
        #1;
        check("lu_unused_en", {27'd0, en}, 32'h1f);
        id_use_rs2 = 1;
        #1;
        check("lu_en",    {27'd0, en}, 32'h07);
        check("lu_idexf", {31'd0, id_ex_flush}, 32'd1);
        step();
        check("lu_stall_cnt", stall_cnt, 32'd1);
        idle();
        #1;
        check("lu_clean_en",    {27'd0, en}, 32'h1f);
        check("lu_clean_idexf", {31'd0, id_ex_flush}, 32'd0);

        // ---------------- load then branch ----------------
        id_is_branch = 1; branch_taken = 1; id_rs1 = 9; id_use_rs1 = 1;
        ex_is_load = 1; ex_rd_we = 1; ex_rd = 9;
        #1;
        check("lb_b_en",    {27'd0, en}, 32'h07);
        check("lb_b_ififf", {31'd0, if_id_flush}, 32'd0);
        step();
        check("lb_b_stall", stall_cnt, 32'd2);
        ex_is_load = 0; ex_rd_we = 0; ex_rd = 0;
        mem_is_load = 1; mem_rd_we = 1; mem_rd = 9; mem_access = 1; dmem_bus.dmem_ready = 1;
        #1;
        check("lb_c_en",   {27'd0, en}, 32'h07);
        check("lb_c_bfwd", {31'd0, branch_forward_a}, 32'd0);
        step();
        check("lb_c_stall", stall_cnt, 32'd3);
        mem_is_load = 0; mem_rd_we = 0; mem_rd = 0; mem_access = 0;
        wb_rd = 9; wb_rd_we = 1;
        #1;
        check("br_en",    {27'd0, en}, 32'h1f);
        check("br_ififf", {31'd0, if_id_flush}, 32'd1);
        step();
        check("br_flush_cnt", flush_cnt, 32'd1);
        idle();
        #1;
        check("br_after_ififf", {31'd0, if_id_flush}, 32'd0);

        // ---------------- memory wait with a taken branch held in ID ----------------
        mem_access = 1; dmem_bus.dmem_ready = 0;
        id_is_branch = 1; branch_taken = 1; id_rs1 = 3; id_use_rs1 = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("mw_en%0d", c),    {27'd0, en}, 32'h00);
            check($sformatf("mw_req%0d", c),   {31'd0, dmem_bus.dmem_req}, 32'd1);
            check($sformatf("mw_ififf%0d", c), {31'd0, if_id_flush}, 32'd0);
            step();
        end
        dmem_bus.dmem_ready = 1;
        #1;
        check("mw_rel_en",    {27'd0, en}, 32'h1f);
        check("mw_rel_req",   {31'd0, dmem_bus.dmem_req}, 32'd1);
        check("mw_rel_ififf", {31'd0, if_id_flush}, 32'd1);
        step();
        check("mw_stall_cnt", stall_cnt, 32'd6);
        check("mw_flush_cnt", flush_cnt, 32'd2);
        idle();
        #1;
        check("mw_run_en",  {27'd0, en}, 32'h1f);
        check("mw_run_req", {31'd0, dmem_bus.dmem_req}, 32'd0);

        // ---------------- timeout ----------------
        mem_access = 1; dmem_bus.dmem_ready = 0;
        step();                           // RUN entry cycle
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("to_en%0d", c),  {27'd0, en}, 32'h00);
            check($sformatf("to_err%0d", c), {31'd0, mem_err}, 32'd0);
            step();
        end
        #1;
        check("to_adv_en",  {27'd0, en}, 32'h1f);
        check("to_adv_req", {31'd0, dmem_bus.dmem_req}, 32'd1);
        step();
        check("to_err_set", {31'd0, mem_err}, 32'd1);
        check("to_stall",   stall_cnt, 32'd10);
        mem_access = 0;
        #1;
        check("to_run_en",  {27'd0, en}, 32'h1f);
        check("to_run_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
        step();
        step();
        check("to_err_sticky", {31'd0, mem_err}, 32'd1);

        // ---------------- async reset mid MEM_WAIT ----------------
        mem_access = 1; dmem_bus.dmem_ready = 0;
        step();
        step();
        check("ar_pre_req", {31'd0, dmem_bus.dmem_req}, 32'd1);
        #2;
        rst_n = 0;
        #1;
        check("ar_req",   {31'd0, dmem_bus.dmem_req}, 32'd0);
        check("ar_stall", stall_cnt, 32'd0);
        check("ar_flush", flush_cnt, 32'd0);
        check("ar_err",   {31'd0, mem_err}, 32'd0);
        step();
        rst_n = 1;
        mem_access = 0;
        #1;
        check("ar_run_en",  {27'd0, en}, 32'h1f);
        check("ar_run_req", {31'd0, dmem_bus.dmem_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
